// File: rtl/biu_constants_pkg.sv
// Bus interface constants shared by the core's memory-side blocks.
// Provides the transfer size encoding used on the dmem_* bus.
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BYTE  = 3'd0,
        HWORD = 3'd1,
        WORD  = 3'd2,
        DWORD = 3'd3,
        QWORD = 3'd4
    } biu_size_t;

endpackage

// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the dmem_responder block:
//   - FSM state encoding
//   - completion kind decided at request accept
//   - LFSR tap mask for the optional random-stall generator
//   - size2be(): write byte enables from transfer size and address lane
package dmem_responder_pkg;
    import biu_constants_pkg::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_resp_state_t;

    typedef enum logic [1:0] {
        RSP_ACK = 2'd0,
        RSP_ERR = 2'd1,
        RSP_MIS = 2'd2
    } dmem_resp_kind_t;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [3:0] size2be(biu_size_t size, logic [1:0] lane);
        logic [3:0] be;
        case (size)
            BYTE:    be = 4'b0001 << lane;
            HWORD:   be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_resp_ram.sv
// Single-port, synchronous, byte-enabled RAM of DEPTH x XLEN words.
// Ports:
//   clk  - clock
//   we   - write strobe (qualified by be)
//   be   - per-byte write enables
//   idx  - word index, shared by read and write
//   d    - write data, already in its byte lanes
//   q    - read data, registered one cycle after idx
// Contents are not reset.
module dmem_resp_ram #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [XLEN/8-1:0]   be,
    input  logic [IDX_W-1:0]    idx,
    input  logic [XLEN-1:0]     d,
    output logic [XLEN-1:0]     q
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < XLEN/8; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= d[8*b +: 8];
                end
            end
        end
        q <= mem[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request at a time on the dmem_* bus,
// services it from a local RAM after LATENCY cycles and returns exactly one
// completion pulse (ack, err or misaligned).
// Ports:
//   clk, rstn        - clock, synchronous active-low reset
//   dmem_req         - request valid, held until the response
//   dmem_adr         - byte address
//   dmem_d           - write data in byte lanes
//   dmem_we          - 1 = write, 0 = read
//   dmem_size        - transfer size
//   dmem_q           - full aligned read word, non-zero only with dmem_ack
//   dmem_ack         - successful completion pulse
//   dmem_err         - bus error completion pulse
//   dmem_misaligned  - misalignment completion pulse
//   dmem_page_fault  - tied 0 (no MMU)
// Build option: define DMEM_RESPONDER_RANDOM_STALL_EN to add 0..3 extra wait
// cycles per request, drawn from an 8-bit LFSR seeded with LFSR_SEED.
module dmem_responder
    import biu_constants_pkg::*;
    import dmem_responder_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] BASE      = 32'h0000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 1,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            dmem_req,
    input  logic [XLEN-1:0] dmem_adr,
    input  logic [XLEN-1:0] dmem_d,
    input  logic            dmem_we,
    input  biu_size_t       dmem_size,
    output logic [XLEN-1:0] dmem_q,
    output logic            dmem_ack,
    output logic            dmem_err,
    output logic            dmem_misaligned,
    output logic            dmem_page_fault
);

    localparam int             IDX_W = $clog2(DEPTH);
    localparam logic [XLEN:0]  SPAN  = (XLEN+1)'(DEPTH) << 2;

    dmem_resp_state_t state, state_nxt;
    logic [4:0]       cnt;
    logic [4:0]       wait_load;
    logic [1:0]       extra;

    logic [XLEN-1:0]  off_live;
    logic [IDX_W-1:0] idx_live;
    dmem_resp_kind_t  kind_live;

    logic [IDX_W-1:0] idx_q;
    logic [XLEN-1:0]  d_q;
    logic             we_q;
    logic [3:0]       be_q;
    dmem_resp_kind_t  kind_q;

    logic             ram_we;
    logic [IDX_W-1:0] ram_idx;
    logic [XLEN-1:0]  ram_q;

    logic             accept;

`ifdef DMEM_RESPONDER_RANDOM_STALL_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign extra = lfsr[1:0];
`else
    assign extra = 2'b00;

    // A zero seed would lock the LFSR; the check only matters when it is built.
    if (LFSR_SEED == 8'h00) begin : g_seed_zero_unused
    end
`endif

    assign accept    = (state == IDLE) && dmem_req;
    assign wait_load = 5'(LATENCY - 1) + {3'b000, extra};

    // Offset wraps for addresses below BASE, so one unsigned compare covers
    // both ends of the window.
    assign off_live = dmem_adr - BASE;
    assign idx_live = off_live[IDX_W+1:2];

    always_comb begin
        kind_live = RSP_ACK;
        if ((dmem_size == HWORD && dmem_adr[0]) ||
            (dmem_size == WORD  && dmem_adr[1:0] != 2'b00)) begin
            kind_live = RSP_MIS;
        end else if (dmem_size == DWORD || dmem_size == QWORD ||
                     {1'b0, off_live} >= SPAN) begin
            kind_live = RSP_ERR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= 5'd0;
        end else if (accept) begin
            cnt <= wait_load;
        end else if (state == WAIT) begin
            cnt <= cnt - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q  <= idx_live;
            d_q    <= dmem_d;
            we_q   <= dmem_we;
            be_q   <= size2be(dmem_size, dmem_adr[1:0]);
            kind_q <= kind_live;
        end
    end

    // cnt reaches zero on the same edge that enters RESP.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (dmem_req) state_nxt = (wait_load == 5'd0) ? RESP : WAIT;
            WAIT: if (cnt == 5'd1) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dmem_ack        = (state == RESP) && (kind_q == RSP_ACK);
        dmem_err        = (state == RESP) && (kind_q == RSP_ERR);
        dmem_misaligned = (state == RESP) && (kind_q == RSP_MIS);
        dmem_page_fault = 1'b0;
        dmem_q          = dmem_ack ? ram_q : '0;
    end

    // The read is issued every cycle; in IDLE it uses the live address so a
    // LATENCY=1 request has its data ready in RESP. The write is gated by rstn
    // so a reset landing on the RESP edge drops it.
    assign ram_idx = (state == IDLE) ? idx_live : idx_q;
    assign ram_we  = (state == RESP) && (kind_q == RSP_ACK) && we_q && rstn;

    dmem_resp_ram #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk (clk),
        .we  (ram_we),
        .be  (be_q),
        .idx (ram_idx),
        .d   (d_q),
        .q   (ram_q)
    );

endmodule
